// File: rtl/display_timing_gen.sv
// Raster timing generator: free-running column/row counters with registered
// sync, blanking and frame-start decode aligned to the presented position.
module display_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_row,
  output logic [9:0] pixel_column,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       fs_q, fs_d;

  // Decode from the next-state counters so the registered flags line up
  // with the position registered on the same edge.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      col_d = '0;
      if (row_q == V_LAST) row_d = '0;
      else                 row_d = row_q + 10'd1;
    end
    hs_d  = (col_d >= HS_FIRST && col_d <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d  = (row_d >= VS_FIRST && row_d <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    von_d = (col_d < H_VIS) && (row_d < V_VIS);
    fs_d  = (col_d == '0) && (row_d == '0);
  end

  // Reset parks the counters one clock before (0,0).
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= H_LAST;
      row_q <= V_LAST;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      von_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      fs_q  <= fs_d;
    end
  end

  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign video_on     = von_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default-size instance plus two reduced-size
// instances (both sync polarities) checked every clock against a position model.
module tb_display_timing_gen;

  localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic [9:0] row;
    logic [9:0] col;
  } outs_t;

  typedef struct {
    int    t;
    outs_t e;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       d0_hs, d0_vs, d0_von, d0_fs;
  logic [9:0] d0_row, d0_col;
  logic       d1_hs, d1_vs, d1_von, d1_fs;
  logic [9:0] d1_row, d1_col;
  logic       d2_hs, d2_vs, d2_von, d2_fs;
  logic [9:0] d2_row, d2_col;

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit in_rst = 1'b1;
  bit started = 1'b0;

  always #5 clock = ~clock;

  display_timing_gen dut0 (
    .clock(clock), .reset(reset),
    .horiz_sync(d0_hs), .vert_sync(d0_vs), .video_on(d0_von),
    .pixel_row(d0_row), .pixel_column(d0_col), .frame_start(d0_fs)
  );

  display_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE(1'b0)
  ) dut1 (
    .clock(clock), .reset(reset),
    .horiz_sync(d1_hs), .vert_sync(d1_vs), .video_on(d1_von),
    .pixel_row(d1_row), .pixel_column(d1_col), .frame_start(d1_fs)
  );

  display_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE(1'b1)
  ) dut2 (
    .clock(clock), .reset(reset),
    .horiz_sync(d2_hs), .vert_sync(d2_vs), .video_on(d2_von),
    .pixel_row(d2_row), .pixel_column(d2_col), .frame_start(d2_fs)
  );

  // Position follows directly from clocks elapsed since reset release.
  function automatic outs_t model(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input logic sa, input bit rst, input int tt);
    outs_t m;
    int ht, vt, c, r;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (rst) begin
      c = ht - 1;
      r = vt - 1;
    end else begin
      c = tt % ht;
      r = (tt / ht) % vt;
    end
    m.col = 10'(c);
    m.row = 10'(r);
    m.hs  = (!rst && c >= ha + hf && c < ha + hf + hsw) ? sa : ~sa;
    m.vs  = (!rst && r >= va + vf && r < va + vf + vsw) ? sa : ~sa;
    m.von = !rst && c < ha && r < va;
    m.fs  = !rst && c == 0 && r == 0;
    return m;
  endfunction

  function automatic vec_t mk(input int tt, input bit hs, input bit vs, input bit von,
                              input bit fs, input int row, input int col);
    vec_t v;
    v.t     = tt;
    v.e.hs  = hs;
    v.e.vs  = vs;
    v.e.von = von;
    v.e.fs  = fs;
    v.e.row = 10'(row);
    v.e.col = 10'(col);
    return v;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d rst=%0b actual hs/vs/von/fs=%b%b%b%b row=%0d col=%0d required hs/vs/von/fs=%b%b%b%b row=%0d col=%0d",
               name, t, in_rst, act.hs, act.vs, act.von, act.fs, act.row, act.col,
               exp.hs, exp.vs, exp.von, exp.fs, exp.row, exp.col);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      in_rst  = 1'b1;
      started = 1'b1;
    end else begin
      if (in_rst) t = 0;
      else        t = t + 1;
      in_rst = 1'b0;
    end
    #1;
    if (started) begin
      check("dut0_default", {d0_hs, d0_vs, d0_von, d0_fs, d0_row, d0_col},
            model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, in_rst, t));
      check("dut1_small", {d1_hs, d1_vs, d1_von, d1_fs, d1_row, d1_col},
            model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, in_rst, t));
      check("dut2_small_inv", {d2_hs, d2_vs, d2_von, d2_fs, d2_row, d2_col},
            model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, in_rst, t));
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while ((in_rst || t < target) && guard < 50000) begin
      tick();
      guard++;
    end
    check_int("run_to_reached", t, target);
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  vec_t tbl[16];
  int   fs_prev;
  int   guard;

  initial begin
    // Reduced instance: hsync cols 23..27, vsync rows 12..13, 32x17 raster.
    tbl[0]  = mk(0,   1, 1, 1, 1, 0,  0);
    tbl[1]  = mk(19,  1, 1, 1, 0, 0,  19);
    tbl[2]  = mk(20,  1, 1, 0, 0, 0,  20);
    tbl[3]  = mk(23,  0, 1, 0, 0, 0,  23);
    tbl[4]  = mk(27,  0, 1, 0, 0, 0,  27);
    tbl[5]  = mk(28,  1, 1, 0, 0, 0,  28);
    tbl[6]  = mk(31,  1, 1, 0, 0, 0,  31);
    tbl[7]  = mk(32,  1, 1, 1, 0, 1,  0);
    tbl[8]  = mk(319, 1, 1, 0, 0, 9,  31);
    tbl[9]  = mk(320, 1, 1, 0, 0, 10, 0);
    tbl[10] = mk(384, 1, 0, 0, 0, 12, 0);
    tbl[11] = mk(407, 0, 0, 0, 0, 12, 23);
    tbl[12] = mk(447, 1, 0, 0, 0, 13, 31);
    tbl[13] = mk(448, 1, 1, 0, 0, 14, 0);
    tbl[14] = mk(543, 1, 1, 0, 0, 16, 31);
    tbl[15] = mk(544, 1, 1, 1, 1, 0,  0);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    for (int unsigned i = 0; i < 16; i++) begin
      guard = 0;
      while ((in_rst || t < tbl[i].t) && guard < 5000) begin
        tick();
        guard++;
      end
      check_int("tbl_time", t, tbl[i].t);
      check("tbl_vec", {d1_hs, d1_vs, d1_von, d1_fs, d1_row, d1_col}, tbl[i].e);
    end

    fs_prev = t;
    while (t < 2 * S_FRAME + 2) begin
      tick();
      if (d1_fs) begin
        check_int("frame_period", t - fs_prev, S_FRAME);
        fs_prev = t;
      end
    end
    check_int("frame_pulse_seen", fs_prev, 2 * S_FRAME);

    // Default raster: first three lines, then reset at (300,1) mid-line.
    run_to(2000);
    pulse_reset(1);
    run_to(1100);
    pulse_reset(1);
    run_to(1700);
    // Reset inside the default hsync pulse.
    pulse_reset(1);
    run_to(700);
    pulse_reset(1);
    // Reset while both syncs are active on the reduced instances.
    run_to(409);
    check_int("small_in_both_syncs", {30'd0, d1_hs, d1_vs}, 0);
    pulse_reset(2);

    repeat (30) begin
      guard = $urandom_range(1, 900);
      repeat (guard) tick();
      pulse_reset($urandom_range(1, 3));
    end
    repeat (600) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
- REQ-001: Parameters, one per line (name, default, meaning):
  - H_ACTIVE, 640, visible pixels per line.
  - H_FP, 16, horizontal front porch in clocks.
  - H_SYNC, 96, horizontal sync width in clocks.
  - H_BP, 48, horizontal back porch in clocks.
  - V_ACTIVE, 480, visible lines per frame.
  - V_FP, 10, vertical front porch in lines.
  - V_SYNC, 2, vertical sync width in lines.
  - V_BP, 33, vertical back porch in lines.
  - SYNC_ACTIVE, 1'b0, asserted level of both sync outputs.
- REQ-002: One clock, named clock; reset is synchronous and active-high, named reset.
- REQ-003: Ports, one per line (name, direction, width, meaning):
  - clock, input, 1, 25 MHz pixel clock.
  - reset, input, 1, synchronous active-high reset.
  - horiz_sync, output, 1, horizontal sync to the display.
  - vert_sync, output, 1, vertical sync to the display.
  - video_on, output, 1, high only inside the visible region.
  - pixel_row, output, 10, current line index, 0..524.
  - pixel_column, output, 10, current pixel index, 0..799.
  - frame_start, output, 1, one-clock pulse at position (0,0).

Function
- REQ-004: Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- REQ-005: Column counter SHALL increment by 1 every clock. At H_TOTAL-1 it SHALL wrap to 0.
- REQ-006: Row counter SHALL increment only on a clock where the column wraps. At V_TOTAL-1, coincident with a column wrap, it SHALL wrap to 0.
- REQ-007: pixel_column and pixel_row SHALL equal the column and row counter registers. They are unsigned 10-bit, never exceed 799/524, and are never masked during blanking.
- REQ-008: All outputs SHALL be registered and mutually aligned. The sync, video_on and frame_start values in a cycle describe the (pixel_row, pixel_column) presented in that same cycle, so decode uses the next-state counter values.
- REQ-009: horiz_sync SHALL equal SYNC_ACTIVE exactly when column is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751. Otherwise it SHALL be ~SYNC_ACTIVE.
- REQ-010: vert_sync SHALL equal SYNC_ACTIVE exactly when row is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, for all columns of those rows. Otherwise it SHALL be ~SYNC_ACTIVE.
- REQ-011: video_on SHALL be 1 exactly when column < H_ACTIVE and row < V_ACTIVE.
- REQ-012: frame_start SHALL be 1 for exactly one clock, when (row, column) = (0,0). It SHALL be 0 at every other position.
- REQ-013: Frame period SHALL be exactly H_TOTAL*V_TOTAL = 420000 clocks. Line period SHALL be exactly 800 clocks, with no jitter or skipped states.
- REQ-014: Downstream consumers SHALL receive pixel_row/pixel_column with zero added latency relative to video_on. Any pipeline delay is the consumer's responsibility.

Reset
- REQ-015: While reset is high at a clock edge, the block SHALL load pixel_column = 799, pixel_row = 524, horiz_sync = ~SYNC_ACTIVE, vert_sync = ~SYNC_ACTIVE, video_on = 0, frame_start = 0. This is the position immediately preceding (0,0).
- REQ-016: On the first edge with reset low, outputs SHALL present (0,0) with video_on = 1, frame_start = 1, and both syncs inactive.
- REQ-017: Reset asserted mid-frame SHALL take effect at the next edge regardless of position. No partial sync pulse may extend beyond that edge.

Verification
- REQ-018: Release reset, then count clocks -> first (0,0) one clock after release with frame_start=1; next frame_start exactly 420000 clocks later.
- REQ-019: Sample row 0 -> video_on high for columns 0..639; horiz_sync low for columns 656..751 (96 clocks); high elsewhere.
- REQ-020: Run a full frame -> vert_sync low for all 1600 clocks of rows 490..491; video_on never high for row >= 480.
- REQ-021: Check wrap boundaries -> (799,523) is followed by (0,524); (799,524) is followed by (0,0); values 800/525 never appear.
- REQ-022: Assert reset for 1 clock at (300,200) -> next cycle shows the REQ-015 values; on release, timing restarts at (0,0).
- REQ-023: Override SYNC_ACTIVE=1 -> sync outputs are inverted relative to REQ-019/REQ-020; all other outputs are unchanged.
